// File: rtl/mult_float_pipe.sv
// mult_float_pipe: 3-stage FP multiplier (valid/ready in, valid/ready out, tag sideband, overflow/underflow/exception flags)
module mult_float_pipe #(
  parameter int EXP_W = 5,
  parameter int MAN_W = 10,
  parameter int TAG_W = 4,
  parameter int ROUND = 1
) (
  input  logic                   i_Clock,
  input  logic                   i_Reset_n,
  input  logic                   i_Valid,
  output logic                   o_Ready,
  input  logic [EXP_W+MAN_W:0]   i_Factor1,
  input  logic [EXP_W+MAN_W:0]   i_Factor2,
  input  logic [TAG_W-1:0]       i_Tag,
  output logic                   o_Valid,
  input  logic                   i_Ready,
  output logic [EXP_W+MAN_W:0]   o_Product,
  output logic [TAG_W-1:0]       o_Tag,
  output logic                   o_Overflow,
  output logic                   o_Underflow,
  output logic                   o_Exception
);
  localparam int W = 1 + EXP_W + MAN_W;
  localparam int PW = 2 * MAN_W + 2;
  localparam int EW = EXP_W + 2;
  localparam int BIAS = 2 ** (EXP_W - 1) - 1;
  localparam int EMAX = 2 ** EXP_W - 1;
  logic adv;
  logic v1_q, v1_d, sgn1_q, sgn1_d, zero1_q, zero1_d;
  logic [TAG_W-1:0] tag1_q, tag1_d;
  logic [PW-1:0] p1_q, p1_d;
  logic signed [EW-1:0] e1_q, e1_d;
  logic v2_q, v2_d, sgn2_q, sgn2_d, zero2_q, zero2_d;
  logic [TAG_W-1:0] tag2_q, tag2_d;
  logic [MAN_W-1:0] man2_q, man2_d;
  logic signed [EW-1:0] e2_q, e2_d;
  logic v3_q, v3_d, ovf_q, ovf_d, unf_q, unf_d;
  logic [TAG_W-1:0] tag3_q, tag3_d;
  logic [W-1:0] prod_q, prod_d;
  logic [PW-2:0] ps;
  logic up, cy, ovf, unf;
  assign adv = ~v3_q | i_Ready;
  assign o_Ready = ~i_Reset_n | adv;
  assign o_Valid = v3_q;
  assign o_Product = prod_q;
  assign o_Tag = tag3_q;
  assign o_Overflow = ovf_q;
  assign o_Underflow = unf_q;
  assign o_Exception = ovf_q | unf_q;
  always_comb begin
    v1_d = i_Valid;
    tag1_d = i_Tag;
    sgn1_d = i_Factor1[W-1] ^ i_Factor2[W-1];
    zero1_d = ~|i_Factor1[MAN_W+:EXP_W] | ~|i_Factor2[MAN_W+:EXP_W];
    p1_d = PW'({1'b1, i_Factor1[MAN_W-1:0]}) * PW'({1'b1, i_Factor2[MAN_W-1:0]});
    e1_d = EW'(i_Factor1[MAN_W+:EXP_W]) + EW'(i_Factor2[MAN_W+:EXP_W]) - EW'(BIAS);
    ps = p1_q[PW-1] ? p1_q[PW-2:0] : {p1_q[PW-3:0], 1'b0};
    up = (ROUND != 0) & ps[MAN_W] & (|ps[MAN_W-1:0] | ps[MAN_W+1]);
    {cy, man2_d} = {1'b0, ps[PW-2 -: MAN_W]} + (MAN_W+1)'(up);
    e2_d = e1_q + EW'(p1_q[PW-1]) + EW'(cy);
    v2_d = v1_q;
    tag2_d = tag1_q;
    sgn2_d = sgn1_q;
    zero2_d = zero1_q;
    ovf = ~zero2_q & (e2_q > $signed(EW'(EMAX)));
    unf = ~zero2_q & (e2_q < $signed(EW'(1)));
    prod_d[W-1] = sgn2_q;
    prod_d[W-2:0] = (zero2_q | unf) ? '0 : ovf ? '1 : {e2_q[EXP_W-1:0], man2_q};
    v3_d = v2_q;
    tag3_d = tag2_q;
    ovf_d = v2_q & ovf;
    unf_d = v2_q & unf;
  end
  always_ff @(posedge i_Clock) begin
    if (!i_Reset_n) begin
      v1_q <= 1'b0;
      sgn1_q <= 1'b0;
      zero1_q <= 1'b0;
      tag1_q <= '0;
      p1_q <= '0;
      e1_q <= '0;
      v2_q <= 1'b0;
      sgn2_q <= 1'b0;
      zero2_q <= 1'b0;
      tag2_q <= '0;
      man2_q <= '0;
      e2_q <= '0;
      v3_q <= 1'b0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
      tag3_q <= '0;
      prod_q <= '0;
    end else if (adv) begin
      v1_q <= v1_d;
      sgn1_q <= sgn1_d;
      zero1_q <= zero1_d;
      tag1_q <= tag1_d;
      p1_q <= p1_d;
      e1_q <= e1_d;
      v2_q <= v2_d;
      sgn2_q <= sgn2_d;
      zero2_q <= zero2_d;
      tag2_q <= tag2_d;
      man2_q <= man2_d;
      e2_q <= e2_d;
      v3_q <= v3_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
      tag3_q <= tag3_d;
      prod_q <= prod_d;
    end
  end
endmodule

// File: tb/tb_mult_float_pipe.sv
// tb_mult_float_pipe: random and directed checks of mult_float_pipe against a behavioural half-precision model
module tb_mult_float_pipe;
  logic clk = 1'b0;
  logic rst_n, i_valid, i_ready;
  logic [15:0] f1, f2;
  logic [3:0] tag;
  logic o_ready, o_valid, o_ovf, o_unf, o_exc;
  logic [15:0] o_prod;
  logic [3:0] o_tag;
  logic t_ready, t_valid, t_ovf, t_unf, t_exc;
  logic [15:0] t_prod;
  logic [3:0] t_tag;
  typedef struct {logic [15:0] a; logic [15:0] b; logic [3:0] t;} op_t;
  op_t q[$];
  op_t cur;
  logic [17:0] e1, e0;
  int n_cmp = 0, n_err = 0, cyc = 0, rmode = 0, h0 = -10, h1 = -10, stalls = 0, lat;
  logic held = 1'b0;
  logic [15:0] hp;
  logic [3:0] ht;
  logic [1:0] hf;
  mult_float_pipe u_dut (
    .i_Clock(clk), .i_Reset_n(rst_n), .i_Valid(i_valid), .o_Ready(o_ready),
    .i_Factor1(f1), .i_Factor2(f2), .i_Tag(tag), .o_Valid(o_valid), .i_Ready(i_ready),
    .o_Product(o_prod), .o_Tag(o_tag), .o_Overflow(o_ovf), .o_Underflow(o_unf), .o_Exception(o_exc)
  );
  mult_float_pipe #(.EXP_W(5), .MAN_W(10), .TAG_W(4), .ROUND(0)) u_dut_t (
    .i_Clock(clk), .i_Reset_n(rst_n), .i_Valid(i_valid), .o_Ready(t_ready),
    .i_Factor1(f1), .i_Factor2(f2), .i_Tag(tag), .o_Valid(t_valid), .i_Ready(i_ready),
    .o_Product(t_prod), .o_Tag(t_tag), .o_Overflow(t_ovf), .o_Underflow(t_unf), .o_Exception(t_exc)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  function automatic logic [17:0] fmul(input logic [15:0] a, input logic [15:0] b, input bit rnd);
    int ea, eb, e, sh;
    longint p, m, r, h;
    logic s;
    s = a[15] ^ b[15];
    ea = int'(a[14:10]);
    eb = int'(b[14:10]);
    if (ea == 0 || eb == 0) return {2'b00, s, 15'd0};
    p = longint'(1024 + int'(a[9:0])) * longint'(1024 + int'(b[9:0]));
    e = ea + eb - 15;
    sh = 10;
    if (p >= (longint'(1) << 21)) begin
      e++;
      sh = 11;
    end
    m = p >> sh;
    r = p - (m << sh);
    h = longint'(1) << (sh - 1);
    if (rnd && (r > h || (r == h && (m % 2) == 1))) m++;
    if (m == 2048) begin
      m = 1024;
      e++;
    end
    if (e > 31) return {2'b10, s, 15'h7FFF};
    if (e < 1) return {2'b01, s, 15'd0};
    return {2'b00, s, 5'(e), 10'(m - 1024)};
  endfunction
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask
  always @(posedge clk) begin
    #1;
    if (rmode == 0) i_ready = 1'b1;
    else if (rmode == 1) i_ready = ($urandom_range(0, 9) < 7);
    else i_ready = !(cyc >= h0 && cyc <= h1);
  end
  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
      held = 1'b0;
    end else begin
      if (held) begin
        chk("hold_valid", o_valid, 1);
        chk("hold_product", o_prod, hp);
        chk("hold_tag", o_tag, ht);
        chk("hold_flags", {o_ovf, o_unf}, hf);
      end
      chk("ready_rule", o_ready, !o_valid || i_ready);
      chk("trunc_valid", t_valid, o_valid);
      chk("exception_rule", o_exc, o_ovf | o_unf);
      if (!o_ready) stalls++;
      if (o_valid) begin
        if (q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_output: got product %h tag %h expected no result", o_prod, o_tag);
        end else if (i_ready) begin
          cur = q.pop_front();
          e1 = fmul(cur.a, cur.b, 1'b1);
          e0 = fmul(cur.a, cur.b, 1'b0);
          chk("product", o_prod, e1[15:0]);
          chk("overflow", o_ovf, e1[17]);
          chk("underflow", o_unf, e1[16]);
          chk("tag", o_tag, cur.t);
          chk("trunc_product", t_prod, e0[15:0]);
          chk("trunc_flags", {t_ovf, t_unf, t_exc}, {e0[17], e0[16], e0[17] | e0[16]});
          chk("trunc_tag", t_tag, cur.t);
        end
      end
      held = o_valid && !i_ready;
      hp = o_prod;
      ht = o_tag;
      hf = {o_ovf, o_unf};
      if (i_valid && o_ready) q.push_back('{f1, f2, tag});
    end
  end
  task automatic send(input logic [15:0] a, input logic [15:0] b, input logic [3:0] t);
    i_valid = 1'b1;
    f1 = a;
    f2 = b;
    tag = t;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (o_ready) begin
        @(posedge clk);
        #1;
        i_valid = 1'b0;
        return;
      end
      @(posedge clk);
      #1;
    end
    n_cmp++;
    n_err++;
    $display("FAIL accept_timeout: got o_Ready=0 for 200 cycles expected acceptance");
    i_valid = 1'b0;
  endtask
  task automatic drain();
    rmode = 0;
    for (int k = 0; k < 100 && q.size() != 0; k++) @(posedge clk);
    #1;
    chk("drain_empty", q.size(), 0);
  endtask
  function automatic logic [15:0] rnd_fp();
    logic [15:0] v;
    v[15] = 1'($urandom_range(0, 1));
    v[14:10] = ($urandom_range(0, 9) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
    v[9:0] = ($urandom_range(0, 3) == 0) ? 10'($urandom_range(0, 15) << 6) : 10'($urandom);
    return v;
  endfunction
  initial begin
    rst_n = 1'b0;
    i_valid = 1'b0;
    i_ready = 1'b1;
    f1 = '0;
    f2 = '0;
    tag = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_valid", o_valid, 0);
    chk("reset_product", o_prod, 0);
    chk("reset_tag", o_tag, 0);
    chk("reset_flags", {o_ovf, o_unf, o_exc}, 0);
    chk("reset_ready", o_ready, 1);
    rst_n = 1'b1;
    chk("pin_1p5x2", fmul(16'h3E00, 16'h4000, 1), {2'b00, 16'h4200});
    chk("pin_1x1", fmul(16'h3C00, 16'h3C00, 1), {2'b00, 16'h3C00});
    chk("pin_rne", fmul(16'h3E01, 16'h3C01, 1), {2'b00, 16'h3E03});
    chk("pin_trunc", fmul(16'h3E01, 16'h3C01, 0), {2'b00, 16'h3E02});
    chk("pin_ovf_pos", fmul(16'h7BFF, 16'h7BFF, 1), {2'b10, 16'h7FFF});
    chk("pin_ovf_neg", fmul(16'hFBFF, 16'h7BFF, 1), {2'b10, 16'hFFFF});
    chk("pin_unf", fmul(16'h8400, 16'h0400, 1), {2'b01, 16'h8000});
    chk("pin_zero", fmul(16'h0000, 16'h7BFF, 1), {2'b00, 16'h0000});
    @(posedge clk);
    #1;
    i_valid = 1'b1;
    f1 = 16'h3E00;
    f2 = 16'h4000;
    tag = 4'd5;
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      i_valid = 1'b0;
      lat++;
    end while (!o_valid && lat < 10);
    chk("latency", lat, 3);
    chk("lat_product", o_prod, 16'h4200);
    chk("lat_tag", o_tag, 4'd5);
    chk("lat_flags", {o_ovf, o_unf, o_exc}, 0);
    send(16'h3C00, 16'h3C00, 4'd1);
    send(16'h3E01, 16'h3C01, 4'd2);
    send(16'h7BFF, 16'h7BFF, 4'd3);
    send(16'hFBFF, 16'h7BFF, 4'd4);
    send(16'h8400, 16'h0400, 4'd6);
    send(16'h0000, 16'h7BFF, 4'd7);
    send(16'h8000, 16'h0000, 4'd8);
    send(16'h7C00, 16'h4000, 4'd9);
    drain();
    h0 = cyc + 3;
    h1 = cyc + 6;
    rmode = 2;
    stalls = 0;
    for (int i = 0; i < 6; i++) send(rnd_fp(), rnd_fp(), 4'(i + 10));
    drain();
    chk("stall_seen", stalls > 0, 1);
    rmode = 1;
    for (int i = 0; i < 400; i++) begin
      send(rnd_fp(), rnd_fp(), 4'($urandom));
      if ($urandom_range(0, 4) == 0) begin
        @(posedge clk);
        #1;
      end
    end
    drain();
    send(16'h4000, 16'h4200, 4'd11);
    send(16'h3C00, 16'h4400, 4'd12);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_fly_valid", o_valid, 0);
    chk("rst_fly_product", o_prod, 0);
    chk("rst_fly_tag", o_tag, 0);
    chk("rst_fly_flags", {o_ovf, o_unf, o_exc}, 0);
    chk("rst_fly_ready", o_ready, 1);
    rst_n = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    chk("rst_discard", o_valid, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end
endmodule
